// File: rtl/result_writer.sv
// Serializes one captured packed vector into the on-chip buffer, one element per
// cycle across a contiguous (wrapping) address range, then holds `finished`.
module result_writer #(
  parameter int MaxWidth  = 9,
  parameter int Depth     = 32,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writeStart,
  input  logic                          stall,
  input  logic [AddrWidth-1:0]          startAddr,
  input  logic [AddrWidth-1:0]          finalAddr,
  input  logic [MaxWidth*DataWidth-1:0] dataIn,
  output logic                          writeEn,
  output logic [AddrWidth-1:0]          writeAddr,
  output logic [DataWidth-1:0]          dataOut,
  output logic                          busy,
  output logic                          finished
);

  // state | meaning
  // IDLE  | waiting for writeStart, nothing captured
  // WRITE | issuing one buffer write per non-stalled cycle
  // DONE  | transfer complete, finished held high until next writeStart
  typedef enum logic [1:0] {IDLE, WRITE, DONE} stateType;

  localparam int CountWidth = $clog2(MaxWidth + 1);
  localparam int VecWidth   = MaxWidth * DataWidth;

  stateType              state, stateNext;
  logic [VecWidth-1:0]   dataReg, dataRegNext;
  logic [AddrWidth-1:0]  addrPtr, addrPtrNext;
  logic [CountWidth-1:0] remaining, remainingNext;
  logic                  writeEnNext, busyNext, finishedNext;
  logic [AddrWidth-1:0]  writeAddrNext;
  logic [DataWidth-1:0]  dataOutNext;

  logic [AddrWidth-1:0]  addrDiff;
  logic [AddrWidth:0]    span;
  logic [CountWidth-1:0] capCount;

  // Subtraction in AddrWidth bits gives the modulo-Depth wrap for free.
  always_comb begin
    addrDiff = finalAddr - startAddr;
    span     = {1'b0, addrDiff} + (AddrWidth+1)'(1);
    if (span > (AddrWidth+1)'(MaxWidth)) capCount = CountWidth'(MaxWidth);
    else                                 capCount = CountWidth'(span);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dataReg   <= '0;
      addrPtr   <= '0;
      remaining <= '0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      dataOut   <= '0;
      busy      <= 1'b0;
      finished  <= 1'b0;
    end else begin
      state     <= stateNext;
      dataReg   <= dataRegNext;
      addrPtr   <= addrPtrNext;
      remaining <= remainingNext;
      writeEn   <= writeEnNext;
      writeAddr <= writeAddrNext;
      dataOut   <= dataOutNext;
      busy      <= busyNext;
      finished  <= finishedNext;
    end
  end

  always_comb begin
    stateNext     = state;
    dataRegNext   = dataReg;
    addrPtrNext   = addrPtr;
    remainingNext = remaining;
    writeEnNext   = 1'b0;
    writeAddrNext = writeAddr;
    dataOutNext   = dataOut;
    busyNext      = 1'b0;
    finishedNext  = 1'b0;

    case (state)
      IDLE, DONE: begin
        finishedNext = (state == DONE);
        if (writeStart) begin
          stateNext     = WRITE;
          dataRegNext   = dataIn;
          addrPtrNext   = startAddr;
          remainingNext = capCount;
          busyNext      = 1'b1;
          finishedNext  = 1'b0;
        end
      end

      WRITE: begin
        busyNext = 1'b1;
        // A stalled cycle freezes everything, including the final hand-off to DONE.
        if (!stall) begin
          if (remaining != '0) begin
            writeEnNext   = 1'b1;
            writeAddrNext = addrPtr;
            dataOutNext   = dataReg[DataWidth-1:0];
            dataRegNext   = dataReg >> DataWidth;
            addrPtrNext   = addrPtr + AddrWidth'(1);
            remainingNext = remaining - CountWidth'(1);
          end else begin
            stateNext    = DONE;
            busyNext     = 1'b0;
            finishedNext = 1'b1;
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: expected (addr,data) writes are queued at
// start and popped as the DUT strobes writeEn; a buffer model tracks untouched words.
module tb_result_writer;

  localparam int MaxWidth  = 9;
  localparam int Depth     = 32;
  localparam int DataWidth = 8;
  localparam int AddrWidth = 5;
  localparam logic [7:0] Sentinel = 8'hEE;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          writeStart;
  logic                          stall;
  logic [AddrWidth-1:0]          startAddr;
  logic [AddrWidth-1:0]          finalAddr;
  logic [MaxWidth*DataWidth-1:0] dataIn;
  logic                          writeEn;
  logic [AddrWidth-1:0]          writeAddr;
  logic [DataWidth-1:0]          dataOut;
  logic                          busy;
  logic                          finished;

  int nChecks = 0;
  int nFails  = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  logic [12:0] expQ[$];
  logic [7:0]  mem[Depth];

  result_writer #(
    .MaxWidth(MaxWidth), .Depth(Depth), .DataWidth(DataWidth), .AddrWidth(AddrWidth)
  ) dut (
    .clk(clk), .rst(rst), .writeStart(writeStart), .stall(stall),
    .startAddr(startAddr), .finalAddr(finalAddr), .dataIn(dataIn),
    .writeEn(writeEn), .writeAddr(writeAddr), .dataOut(dataOut),
    .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (rst && writeEn) mem[writeAddr] <= dataOut;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && writeEn) begin
      if (expQ.size() == 0) begin
        check("spuriousWrite", 32'(writeEn), 32'(0));
      end else begin
        logic [12:0] e;
        e = expQ.pop_front();
        check("writeAddr", 32'(writeAddr), 32'(e[12:8]));
        check("writeData", 32'(dataOut), 32'(e[7:0]));
      end
    end
  end

  // Drives a one-cycle writeStart; when accepted, queues the writes it should cause.
  task automatic startXfer(input int sa, input int fa, input int base, input bit accept);
    logic [MaxWidth*DataWidth-1:0] vec;
    int n;
    for (int i = 0; i < MaxWidth; i++) vec[i*DataWidth +: DataWidth] = 8'(base + i);
    @(negedge clk);
    startAddr  = AddrWidth'(sa);
    finalAddr  = AddrWidth'(fa);
    dataIn     = vec;
    writeStart = 1'b1;
    @(posedge clk); #1;
    writeStart = 1'b0;
    dataIn     = ~vec;
    if (accept) begin
      startCycle = cycleCnt;
      n = ((fa - sa + Depth) % Depth) + 1;
      if (n > MaxWidth) n = MaxWidth;
      for (int k = 0; k < n; k++)
        expQ.push_back({5'((sa + k) % Depth), 8'(base + k)});
      check("busyAfterStart", 32'(busy), 32'(1));
      check("finishedAfterStart", 32'(finished), 32'(0));
    end
  endtask

  task automatic waitDone(input int expLat);
    int guard = 0;
    while (!finished && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("latency", 32'(cycleCnt - startCycle), 32'(expLat));
    check("pendingWrites", 32'(expQ.size()), 32'(0));
    check("busyAtDone", 32'(busy), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = Sentinel;
    rst = 1'b0; writeStart = 1'b0; stall = 1'b0;
    startAddr = '0; finalAddr = '0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rstWriteEn", 32'(writeEn), 32'(0));
    check("rstWriteAddr", 32'(writeAddr), 32'(0));
    check("rstDataOut", 32'(dataOut), 32'(0));
    check("rstBusy", 32'(busy), 32'(0));
    check("rstFinished", 32'(finished), 32'(0));
    @(negedge clk); rst = 1'b1;

    // Basic 4..8
    startXfer(4, 8, 'h10, 1'b1);
    waitDone(6);
    check("word9Untouched", 32'(mem[9]), 32'(Sentinel));
    check("word8Written", 32'(mem[8]), 32'(8'h14));

    // Wrap, then clamp
    startXfer(30, 1, 'h30, 1'b1);
    waitDone(5);
    startXfer(0, 20, 'h50, 1'b1);
    waitDone(10);
    check("clampWord9Untouched", 32'(mem[9]), 32'(Sentinel));

    // Stall two cycles after the first write
    startXfer(0, 2, 'h60, 1'b1);
    @(posedge clk); #1;
    check("firstWriteEn", 32'(writeEn), 32'(1));
    stall = 1'b1;
    @(posedge clk); #1;
    check("stallWriteEn", 32'(writeEn), 32'(0));
    check("stallAddrHold", 32'(writeAddr), 32'(0));
    check("stallDataHold", 32'(dataOut), 32'(8'h60));
    @(posedge clk); #1;
    stall = 1'b0;
    waitDone(6);

    // Ignored start mid-transfer, then restart from DONE
    startXfer(4, 8, 'h70, 1'b1);
    @(posedge clk); #1;
    startXfer(20, 25, 'h90, 1'b0);
    waitDone(6);
    check("ignoredWord20", 32'(mem[20]), 32'(Sentinel));
    startXfer(24, 26, 'hA0, 1'b1);
    waitDone(4);

    // Single element
    startXfer(17, 17, 'hB0, 1'b1);
    waitDone(2);
    check("singleWord18", 32'(mem[18]), 32'(Sentinel));

    // Async reset in the middle of write 2 of 5
    startXfer(10, 14, 'hC0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arstWriteEn", 32'(writeEn), 32'(0));
    check("arstWriteAddr", 32'(writeAddr), 32'(0));
    check("arstDataOut", 32'(dataOut), 32'(0));
    check("arstBusy", 32'(busy), 32'(0));
    check("arstFinished", 32'(finished), 32'(0));
    expQ.delete();
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("postRstBusy", 32'(busy), 32'(0));
    check("postRstFinished", 32'(finished), 32'(0));
    check("word10Written", 32'(mem[10]), 32'(8'hC0));
    check("word11Untouched", 32'(mem[11]), 32'(Sentinel));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
